// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the AES control sequencer.
// Contents: sequencer state enum, default block width, pointer-width helper.
package aes_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StWait  = 2'd2
  } aes_state_e;

  localparam int unsigned DefaultDataW = 128;

  // Bits needed to index `value` entries; never less than 1.
  function automatic int unsigned log2_ceil(int unsigned value);
    int unsigned width;
    width = 1;
    while ((32'd1 << width) < value) begin
      width = width + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/aes_ctrl_rfifo.sv
// Result FIFO between the AES core and the TX drain.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset (empties the FIFO)
//   push_i, wdata_i write strobe and data
//   pop_i           read strobe; rdata_o is the show-ahead head
//   count_o         current number of stored entries
// Depth must be a power of two so the pointers wrap naturally.
module aes_ctrl_rfifo
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned DataW = DefaultDataW,
  parameter int unsigned Depth = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              push_i,
  input  logic [DataW-1:0]                  wdata_i,
  input  logic                              pop_i,
  output logic [DataW-1:0]                  rdata_o,
  output logic [log2_ceil(Depth+1)-1:0]     count_o
);

  localparam int unsigned AddrW = log2_ceil(Depth);
  localparam int unsigned CntW  = log2_ceil(Depth + 1);

  logic [DataW-1:0] mem_q [Depth];
  logic [AddrW-1:0] wptr_q, wptr_d;
  logic [AddrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_i) wptr_d = wptr_q + AddrW'(1);
    if (pop_i)  rptr_d = rptr_q + AddrW'(1);
    if (push_i && !pop_i) begin
      count_d = count_q + CntW'(1);
    end else if (!push_i && pop_i) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; the count gates every read.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

  // Admission control upstream reserves a slot for every block in flight.
  push_not_full_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                     !(push_i && (count_q == CntW'(Depth))));

endmodule

// File: rtl/aes_ctrl_seq.sv
// AES control sequencer: pops blocks from the RX FIFO, launches the AES core one block at a
// time, buffers results in a local FIFO and drains them to TX independently of the FSM.
// Ports:
//   clk, reset (async, active-low)
//   d_in_rx, rx_empty, rx_rd        RX FIFO head / empty / pop strobe
//   d_out_aes, aes_start            block and launch pulse to the AES core
//   aes_done, d_in_aes              AES completion pulse and result
//   d_out_tx, tx_wr, tx_hasSpace    TX data, write strobe, flow control
//   busy, blk_count, timeout_err    status
// Optional feature: define AES_CTRL_TIMEOUT_EN to enable the WAIT-state watchdog
// (TIMEOUT_CYC cycles); otherwise timeout_err is tied low.
module aes_ctrl_seq
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W      = DefaultDataW,
  parameter int unsigned OUT_DEPTH   = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] d_in_rx,
  input  logic              rx_empty,
  output logic              rx_rd,
  output logic [DATA_W-1:0] d_out_aes,
  output logic              aes_start,
  input  logic              aes_done,
  input  logic [DATA_W-1:0] d_in_aes,
  output logic [DATA_W-1:0] d_out_tx,
  output logic              tx_wr,
  input  logic              tx_hasSpace,
  output logic              busy,
  output logic [CNT_W-1:0]  blk_count,
  output logic              timeout_err
);

  localparam int unsigned FifoCntW = log2_ceil(OUT_DEPTH + 1);

  aes_state_e state_q, state_d;
  logic              rx_rd_q, rx_rd_d;
  logic              aes_start_q, aes_start_d;
  logic [DATA_W-1:0] d_out_aes_q, d_out_aes_d;
  logic [DATA_W-1:0] d_out_tx_q, d_out_tx_d;
  logic              tx_wr_q, tx_wr_d;
  logic [CNT_W-1:0]  blk_count_q, blk_count_d;

  logic                push, drain, admit, wd_expired;
  logic [31:0]         occ_after;
  logic [DATA_W-1:0]   fifo_head;
  logic [FifoCntW-1:0] fifo_count;

  aes_ctrl_rfifo #(
    .DataW (DATA_W),
    .Depth (OUT_DEPTH)
  ) u_rfifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (push),
    .wdata_i (d_in_aes),
    .pop_i   (drain),
    .rdata_o (fifo_head),
    .count_o (fifo_count)
  );

  // Drain side: registered TX strobe, independent of the FSM.
  always_comb begin
    drain       = (fifo_count != '0) && tx_hasSpace;
    tx_wr_d     = drain;
    d_out_tx_d  = drain ? fifo_head : d_out_tx_q;
    blk_count_d = blk_count_q + CNT_W'(drain);
  end

  // A same-edge drain already frees its slot, so count it before admitting.
  always_comb begin
    occ_after = 32'(fifo_count) + 32'd1 - 32'(drain);
    admit     = (state_q == StIdle) && !rx_empty && (occ_after <= OUT_DEPTH);
  end

  always_comb begin
    state_d     = state_q;
    rx_rd_d     = 1'b0;
    aes_start_d = 1'b0;
    d_out_aes_d = d_out_aes_q;
    push        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (admit) begin
          state_d     = StStart;
          rx_rd_d     = 1'b1;
          aes_start_d = 1'b1;
          d_out_aes_d = d_in_rx;
        end
      end
      StStart: state_d = StWait;
      StWait: begin
        if (aes_done) begin
          push    = 1'b1;
          state_d = StIdle;
        end else if (wd_expired) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      rx_rd_q     <= 1'b0;
      aes_start_q <= 1'b0;
      d_out_aes_q <= '0;
      d_out_tx_q  <= '0;
      tx_wr_q     <= 1'b0;
      blk_count_q <= '0;
    end else begin
      state_q     <= state_d;
      rx_rd_q     <= rx_rd_d;
      aes_start_q <= aes_start_d;
      d_out_aes_q <= d_out_aes_d;
      d_out_tx_q  <= d_out_tx_d;
      tx_wr_q     <= tx_wr_d;
      blk_count_q <= blk_count_d;
    end
  end

`ifdef AES_CTRL_TIMEOUT_EN
  localparam int unsigned WdW = log2_ceil(TIMEOUT_CYC + 1);

  logic [WdW-1:0] wd_q, wd_d;
  logic           timeout_q, timeout_d;

  // wd_q counts completed WAIT cycles; expiry fires on the TIMEOUT_CYC-th one.
  always_comb begin
    wd_d = wd_q;
    if (state_q == StStart) begin
      wd_d = '0;
    end else if (state_q == StWait) begin
      wd_d = wd_q + WdW'(1);
    end
    wd_expired = (state_q == StWait) && !aes_done && (wd_q == WdW'(TIMEOUT_CYC - 1));
    timeout_d  = timeout_q | wd_expired;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_err = timeout_q;
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign wd_expired         = 1'b0;
  assign timeout_err        = 1'b0;
`endif

  assign rx_rd     = rx_rd_q;
  assign aes_start = aes_start_q;
  assign d_out_aes = d_out_aes_q;
  assign d_out_tx  = d_out_tx_q;
  assign tx_wr     = tx_wr_q;
  assign blk_count = blk_count_q;
  assign busy      = (state_q != StIdle) || (fifo_count != '0);

endmodule

// File: tb/tb_aes_ctrl_seq.sv
// Directed self-checking bench for aes_ctrl_seq. Models the RX FIFO, an AES core with
// configurable latency and a TX sink. Build with AES_CTRL_TIMEOUT_EN to cover the watchdog.
module tb_aes_ctrl_seq;

  localparam int unsigned DataW = 128;
  localparam int unsigned CntW  = 4;
  localparam logic [127:0] XMask = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
  localparam logic [127:0] A5Blk = {16{8'hA5}};

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [DataW-1:0] d_in_rx = '0;
  logic             rx_empty = 1'b1;
  logic             rx_rd;
  logic [DataW-1:0] d_out_aes;
  logic             aes_start;
  logic             aes_done = 1'b0;
  logic [DataW-1:0] d_in_aes = '0;
  logic [DataW-1:0] d_out_tx;
  logic             tx_wr;
  logic             tx_hasSpace = 1'b0;
  logic             busy;
  logic [CntW-1:0]  blk_count;
  logic             timeout_err;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  aes_ctrl_seq #(
    .DATA_W      (DataW),
    .OUT_DEPTH   (4),
    .CNT_W       (CntW),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .d_in_rx     (d_in_rx),
    .rx_empty    (rx_empty),
    .rx_rd       (rx_rd),
    .d_out_aes   (d_out_aes),
    .aes_start   (aes_start),
    .aes_done    (aes_done),
    .d_in_aes    (d_in_aes),
    .d_out_tx    (d_out_tx),
    .tx_wr       (tx_wr),
    .tx_hasSpace (tx_hasSpace),
    .busy        (busy),
    .blk_count   (blk_count),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // RX FIFO model (show-ahead).
  logic [DataW-1:0] rx_q[$];
  always @(posedge clk) begin
    if (rx_rd && rx_q.size() > 0) void'(rx_q.pop_front());
    #1;
    rx_empty = (rx_q.size() == 0);
    d_in_rx  = rx_empty ? '0 : rx_q[0];
  end

  // AES model: result d_out_aes ^ XMask (or a constant) resp_lat cycles after aes_start.
  int               resp_lat = 5;
  int               resp_cnt = 0;
  logic             resp_mute = 1'b0;
  logic             resp_const_en = 1'b0;
  logic [DataW-1:0] resp_const = '0;
  logic [DataW-1:0] resp_val = '0;
  always @(posedge clk) begin
    if (aes_start) begin
      resp_cnt = resp_lat;
      resp_val = resp_const_en ? resp_const : (d_out_aes ^ XMask);
    end else if (resp_cnt != 0) begin
      resp_cnt = resp_cnt - 1;
    end
    #1;
    aes_done = (resp_cnt == 1) && !resp_mute;
    d_in_aes = aes_done ? resp_val : '0;
  end

  // Monitor: pulse counts and edge indices sampled at the active edge.
  int               edge_cnt = 0;
  int               n_rx = 0, n_start = 0, n_tx = 0, n_done = 0;
  int               rx_edge = 0, start_edge = 0, done_edge = 0;
  logic [DataW-1:0] tx_log[$];
  int               tx_edge[$];
  always @(posedge clk) begin
    edge_cnt++;
    if (rx_rd) begin n_rx++; rx_edge = edge_cnt; end
    if (aes_start) begin n_start++; start_edge = edge_cnt; end
    if (aes_done) begin n_done++; done_edge = edge_cnt; end
    if (tx_wr) begin n_tx++; tx_log.push_back(d_out_tx); tx_edge.push_back(edge_cnt); end
  end

  logic [CntW-1:0] exp_cnt = '0;

  function automatic logic [DataW-1:0] blk(int i);
    return {4{32'hC0DE_0000 | 32'(i)}};
  endfunction

  task automatic clear_mon();
    n_rx = 0; n_start = 0; n_tx = 0; n_done = 0;
    tx_log.delete(); tx_edge.delete();
    resp_mute = 1'b0; resp_const_en = 1'b0;
  endtask

  task automatic test_reset();
    n_vec++; if (rx_rd !== 1'b0) begin n_bad++; $display("FAIL rst_rx_rd got %0h want 0", rx_rd); end
    n_vec++; if (aes_start !== 1'b0) begin n_bad++; $display("FAIL rst_start got %0h want 0", aes_start); end
    n_vec++; if (tx_wr !== 1'b0) begin n_bad++; $display("FAIL rst_tx_wr got %0h want 0", tx_wr); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %0h want 0", busy); end
    n_vec++; if (blk_count !== '0) begin n_bad++; $display("FAIL rst_cnt got %0h want 0", blk_count); end
    n_vec++; if (d_out_aes !== '0) begin n_bad++; $display("FAIL rst_d_aes got %0h want 0", d_out_aes); end
    n_vec++; if (d_out_tx !== '0) begin n_bad++; $display("FAIL rst_d_tx got %0h want 0", d_out_tx); end
    n_vec++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL rst_terr got %0h want 0", timeout_err); end
  endtask

  task automatic test_single();
    logic [DataW-1:0] in_blk;
    logic [DataW-1:0] got;
    in_blk = 128'h00112233445566778899AABBCCDDEEFF;
    clear_mon();
    resp_const_en = 1'b1; resp_const = A5Blk; resp_lat = 5; tx_hasSpace = 1'b1;
    rx_q.push_back(in_blk);
    for (int i = 0; i < 60 && n_tx < 1; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    exp_cnt = exp_cnt + 1'b1;
    got = (tx_log.size() > 0) ? tx_log[0] : '0;
    n_vec++; if (n_rx != 1) begin n_bad++; $display("FAIL single_rx_rd got %0d want 1", n_rx); end
    n_vec++; if (n_start != 1) begin n_bad++; $display("FAIL single_start got %0d want 1", n_start); end
    n_vec++; if (n_tx != 1) begin n_bad++; $display("FAIL single_tx_wr got %0d want 1", n_tx); end
    n_vec++; if (got !== A5Blk) begin n_bad++; $display("FAIL single_tx_data got %0h want %0h", got, A5Blk); end
    n_vec++; if (d_out_tx !== A5Blk) begin n_bad++; $display("FAIL single_tx_hold got %0h want %0h", d_out_tx, A5Blk); end
    n_vec++; if (d_out_aes !== in_blk) begin n_bad++; $display("FAIL single_aes_hold got %0h want %0h", d_out_aes, in_blk); end
    n_vec++; if (blk_count !== exp_cnt) begin n_bad++; $display("FAIL single_cnt got %0d want %0d", blk_count, exp_cnt); end
    // rx_rd and aes_start are both registered off the admission edge.
    n_vec++; if (start_edge != rx_edge) begin n_bad++; $display("FAIL single_rx2start got %0d want %0d", start_edge, rx_edge); end
    n_vec++; if (tx_edge.size() == 0 || tx_edge[0] - done_edge != 2) begin
      n_bad++; $display("FAIL single_done2tx got %0d want 2", (tx_edge.size() > 0) ? tx_edge[0] - done_edge : -1);
    end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_idle_busy got %0h want 0", busy); end
  endtask

  task automatic test_backpressure();
    logic [DataW-1:0] got;
    clear_mon();
    resp_lat = 2; tx_hasSpace = 1'b0;
    for (int i = 0; i < 6; i++) rx_q.push_back(blk(i));
    repeat (80) @(negedge clk);
    n_vec++; if (n_start != 4) begin n_bad++; $display("FAIL bp_starts got %0d want 4", n_start); end
    n_vec++; if (n_rx != 4) begin n_bad++; $display("FAIL bp_rx_rd got %0d want 4", n_rx); end
    n_vec++; if (n_tx != 0) begin n_bad++; $display("FAIL bp_no_tx got %0d want 0", n_tx); end
    n_vec++; if (rx_q.size() != 2) begin n_bad++; $display("FAIL bp_rx_left got %0d want 2", rx_q.size()); end
    n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL bp_busy got %0h want 1", busy); end
    tx_hasSpace = 1'b1;
    for (int i = 0; i < 200 && n_tx < 6; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    n_vec++; if (n_tx != 6) begin n_bad++; $display("FAIL bp_tx_total got %0d want 6", n_tx); end
    for (int i = 0; i < 6; i++) begin
      got = (tx_log.size() > i) ? tx_log[i] : '0;
      n_vec++; if (got !== (blk(i) ^ XMask)) begin
        n_bad++; $display("FAIL bp_order[%0d] got %0h want %0h", i, got, blk(i) ^ XMask);
      end
    end
    n_vec++; if (tx_edge.size() < 4 || tx_edge[3] - tx_edge[0] != 3) begin
      n_bad++; $display("FAIL bp_b2b got %0d want 3", (tx_edge.size() > 3) ? tx_edge[3] - tx_edge[0] : -1);
    end
    exp_cnt = exp_cnt + 4'd6;
    n_vec++; if (blk_count !== exp_cnt) begin n_bad++; $display("FAIL bp_cnt got %0d want %0d", blk_count, exp_cnt); end
  endtask

  task automatic test_push_pop();
    logic [DataW-1:0] got;
    logic             seen;
    clear_mon();
    resp_lat = 3; tx_hasSpace = 1'b0;
    rx_q.push_back(blk(10)); rx_q.push_back(blk(11));
    repeat (30) @(negedge clk);
    rx_q.push_back(blk(12));
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = aes_done;
    end
    tx_hasSpace = 1'b1;   // pop lands on the same edge as the push
    @(negedge clk);
    tx_hasSpace = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (seen !== 1'b1) begin n_bad++; $display("FAIL pp_done_seen got %0h want 1", seen); end
    n_vec++; if (n_tx != 1) begin n_bad++; $display("FAIL pp_one_tx got %0d want 1", n_tx); end
    n_vec++; if (tx_edge.size() == 0 || tx_edge[0] - done_edge != 1) begin
      n_bad++; $display("FAIL pp_tx_edge got %0d want 1", (tx_edge.size() > 0) ? tx_edge[0] - done_edge : -1);
    end
    tx_hasSpace = 1'b1;
    for (int i = 0; i < 40 && n_tx < 3; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    n_vec++; if (n_tx != 3) begin n_bad++; $display("FAIL pp_total got %0d want 3", n_tx); end
    for (int i = 0; i < 3; i++) begin
      got = (tx_log.size() > i) ? tx_log[i] : '0;
      n_vec++; if (got !== (blk(10 + i) ^ XMask)) begin
        n_bad++; $display("FAIL pp_order[%0d] got %0h want %0h", i, got, blk(10 + i) ^ XMask);
      end
    end
    exp_cnt = exp_cnt + 4'd3;
    n_vec++; if (blk_count !== exp_cnt) begin n_bad++; $display("FAIL pp_cnt got %0d want %0d", blk_count, exp_cnt); end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    resp_lat = 10; tx_hasSpace = 1'b0;
    for (int i = 0; i < 3; i++) rx_q.push_back(blk(20 + i));
    for (int i = 0; i < 100 && n_start < 3; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rm_busy_pre got %0h want 1", busy); end
    reset = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rm_busy got %0h want 0", busy); end
    n_vec++; if (blk_count !== '0) begin n_bad++; $display("FAIL rm_cnt got %0d want 0", blk_count); end
    n_vec++; if (d_out_aes !== '0) begin n_bad++; $display("FAIL rm_d_aes got %0h want 0", d_out_aes); end
    n_vec++; if (d_out_tx !== '0) begin n_bad++; $display("FAIL rm_d_tx got %0h want 0", d_out_tx); end
    n_vec++; if ({rx_rd, aes_start, tx_wr} !== 3'b000) begin
      n_bad++; $display("FAIL rm_strobes got %0b want 000", {rx_rd, aes_start, tx_wr});
    end
    @(negedge clk);
    reset = 1'b1;
    exp_cnt = '0;
    tx_hasSpace = 1'b1;
    n_done = 0;
    repeat (20) @(negedge clk);
    n_vec++; if (n_done < 1) begin n_bad++; $display("FAIL rm_stale_applied got %0d want >=1", n_done); end
    n_vec++; if (n_tx != 0) begin n_bad++; $display("FAIL rm_stale_tx got %0d want 0", n_tx); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rm_busy_post got %0h want 0", busy); end
  endtask

  task automatic test_timeout();
    logic [DataW-1:0] got;
    clear_mon();
    resp_mute = 1'b1; resp_lat = 2; tx_hasSpace = 1'b1;
    rx_q.push_back(blk(30));
`ifdef AES_CTRL_TIMEOUT_EN
    for (int i = 0; i < 40 && aes_start !== 1'b1; i++) @(negedge clk);
    @(posedge clk);
    repeat (7) @(posedge clk);
    @(negedge clk);
    n_vec++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL to_early got %0h want 0", timeout_err); end
    n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL to_wait_busy got %0h want 1", busy); end
    @(negedge clk);
    n_vec++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL to_set got %0h want 1", timeout_err); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL to_idle got %0h want 0", busy); end
    resp_mute = 1'b0;
    rx_q.push_back(blk(31));
    for (int i = 0; i < 40 && n_tx < 1; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    got = (tx_log.size() > 0) ? tx_log[0] : '0;
    n_vec++; if (n_tx != 1) begin n_bad++; $display("FAIL to_next_tx got %0d want 1", n_tx); end
    n_vec++; if (got !== (blk(31) ^ XMask)) begin
      n_bad++; $display("FAIL to_next_data got %0h want %0h", got, blk(31) ^ XMask);
    end
    n_vec++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL to_sticky got %0h want 1", timeout_err); end
    exp_cnt = exp_cnt + 1'b1;
`else
    repeat (40) @(negedge clk);
    n_vec++; if (n_start != 1) begin n_bad++; $display("FAIL nto_start got %0d want 1", n_start); end
    n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL nto_wait got %0h want 1", busy); end
    n_vec++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL nto_terr got %0h want 0", timeout_err); end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    exp_cnt = '0;
    resp_mute = 1'b0;
`endif
  endtask

  task automatic test_wrap();
    logic [DataW-1:0] got;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    exp_cnt = '0;
    clear_mon();
    resp_lat = 1; tx_hasSpace = 1'b1;
    n_vec++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL wrap_terr_clr got %0h want 0", timeout_err); end
    for (int i = 0; i < 17; i++) rx_q.push_back(blk(40 + i));
    for (int i = 0; i < 400 && n_tx < 17; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    got = (tx_log.size() > 16) ? tx_log[16] : '0;
    n_vec++; if (n_tx != 17) begin n_bad++; $display("FAIL wrap_tx got %0d want 17", n_tx); end
    n_vec++; if (blk_count !== 4'd1) begin n_bad++; $display("FAIL wrap_cnt got %0d want 1", blk_count); end
    n_vec++; if (got !== (blk(56) ^ XMask)) begin
      n_bad++; $display("FAIL wrap_last got %0h want %0h", got, blk(56) ^ XMask);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    test_single();
    test_backpressure();
    test_push_pop();
    test_reset_mid();
    test_timeout();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got stuck want finish");
    $fatal(1);
  end

endmodule
